score_bcd_tracker: RTL and testbench
====================================

# score_bcd_tracker

Sequential score formatter between the game display logic and the 7-segment driver. It samples the 11-bit running score and converts it to 3-digit BCD with an iterative shift-add-3 (double-dabble) engine, replacing combinational divide/modulo. It also keeps a best-score register updated on death, and assembles the 32-bit word for the 8-digit segment display.

## Interface
Parameters:
- `SAT_VALUE`, default 999: binary clamp applied before conversion. The maximum displayable value per 3-digit field.

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `state` in 2: game state (0 = wait, 1 = flying, 2 = dead).
- `score` in 11: current binary score.
- `clear_best` in 1: synchronous, level; zeroes the best score.
- `score_bcd` out 12: BCD of the clamped current score (digits [11:8] hundreds, [7:4] tens, [3:0] ones).
- `best_bcd` out 12: BCD of the clamped best score.
- `disp_data` out 32: `{best_bcd, 8'h00, score_bcd}`; digits 7..5 show best, digits 4..3 show 0, digits 2..0 show current.
- `bcd_valid` out 1: high when both BCD outputs match the current binary sources.
- `new_best` out 1: high from the death that set a new best until `state` returns to 0.
- `sat` out 1: high while the clamped current score is below `score` (i.e. `score` exceeds `SAT_VALUE`).

## Operation
- Registers: `best_bin[10:0]`, `last_cur[10:0]`, `last_best[10:0]`, `prev_state[1:0]`, shift register `{bcd[11:0], bin[10:0]}`, 4-bit shift counter, `target` flag (0 = current, 1 = best).
- Best-score update, evaluated every cycle:
  - A death edge is `state==2 && prev_state!=2`.
  - On a death edge with `score > best_bin`: `best_bin<=score` and `new_best<=1`.
  - `new_best<=0` when `state==0`.
  - `clear_best` has priority over a same-cycle death edge: `best_bin<=0` and `new_best<=0`.
- Pending conditions:
  - `pend_cur = (score != last_cur)`
  - `pend_best = (best_bin != last_best)`
  - Current has priority when both are pending.
- FSM states and transitions:
  - IDLE: if `pend_cur`, go to LOAD with `target=0`; else if `pend_best`, go to LOAD with `target=1`; else stay.
  - LOAD (1 cycle):
    - Latch source `v` (`score` or `best_bin`) into `last_cur` or `last_best`.
    - `bin <= min(v, SAT_VALUE)`, `bcd <= 0`, `cnt <= 0`.
  - SHIFT (11 cycles):
    - Add 3 to every BCD nibble that is ≥5.
    - Then shift `{bcd, bin}` left by 1 and increment `cnt`.
    - Leave when `cnt==10` has shifted.
  - STORE (1 cycle): write `bcd` to `score_bcd` or `best_bcd` per `target`, then go to IDLE.
- One conversion takes 13 cycles (LOAD + 11 SHIFT + STORE).
- `bcd_valid = (fsm==IDLE) && !pend_cur && !pend_best`, registered-consistent.
- `sat` is updated in STORE for `target=0`: `sat<=(last_cur > SAT_VALUE)`.
- `disp_data` is combinational from the output registers.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - all outputs 0;
  - `best_bin`, `last_cur`, `last_best` = 0;
  - `prev_state` = 0;
  - FSM = IDLE.
- Reset asserted mid-conversion aborts the conversion with no STORE.
- Latency from a `score` change to updated `score_bcd`: 14 cycles (1 IDLE detect + 13).
- A death edge that raises `best_bin` to an already-pending current score yields `best_bcd` updated within 28 cycles.
- A `score` change during a conversion:
  - the in-flight conversion completes with its latched value;
  - `bcd_valid` stays low;
  - the next IDLE re-detects the change and reconverts.
- Outputs never show partially shifted data. `score_bcd` and `best_bcd` change only in STORE.
- Wrap-around and clamping: 11-bit inputs up to 2047 are clamped to 999. The BCD result is always a legal digit set (each nibble ≤ 9).

## Test plan
- Reset release with `score=0`: all outputs are 0. `bcd_valid`=1 on the first IDLE cycle with nothing pending. `disp_data`=32'h0.
- `score` 0→123 at cycle t:
  - `bcd_valid`=0 from t+1;
  - `score_bcd`=12'h123 and `disp_data`=32'h0000_0123 at t+14;
  - `bcd_valid`=1 at t+15.
- `score=1500`: `score_bcd`=12'h999 and `sat`=1. Then `score=42`: `score_bcd`=12'h042 and `sat`=0.
- Best-score sequence:
  - `score=57` with `state` 1→2: `best_bcd`=12'h057, `new_best`=1.
  - `state`→0: `new_best` clears.
  - Next death with `score=30`: `best_bcd` stays 12'h057 and `new_best` stays 0.
- `clear_best` asserted in the same cycle as a death edge with `score=80`: `best_bcd`=12'h000 and `new_best`=0.
- Change `score` every 5 cycles for 40 cycles, then hold at 321:
  - no illegal nibble ever appears on `score_bcd`;
  - the final value is 12'h321 with `bcd_valid`=1.
- Assert `rst` low at SHIFT cycle 6: all outputs are 0 immediately, with no stale STORE after release.

Source files
------------

// File: rtl/score_bcd_tracker.sv
// Score formatter: samples current and best scores, converts each to
// 3-digit BCD with a serial shift-add-3 engine, and packs the display word.
module score_bcd_tracker #(
  parameter int unsigned SAT_VALUE = 999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  state,
  input  logic [10:0] score,
  input  logic        clear_best,
  output logic [11:0] score_bcd,
  output logic [11:0] best_bcd,
  output logic [31:0] disp_data,
  output logic        bcd_valid,
  output logic        new_best,
  output logic        sat
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    STORE
  } fsm_t;

  localparam logic [10:0] SAT = 11'(SAT_VALUE);

  fsm_t        fsm;
  fsm_t        fsm_nxt;
  logic [10:0] best_bin;
  logic [10:0] last_cur;
  logic [10:0] last_best;
  logic [1:0]  prev_state;
  logic [11:0] bcd;
  logic [10:0] bin;
  logic [3:0]  cnt;
  logic        target;
  logic        tgt_nxt;
  logic        death;
  logic        pend_cur;
  logic        pend_best;
  logic [10:0] src;
  logic [10:0] src_sat;
  logic [11:0] bcd_adj;

  assign death     = (state == 2'd2) && (prev_state != 2'd2);
  assign pend_cur  = (score != last_cur);
  assign pend_best = (best_bin != last_best);
  assign src       = target ? best_bin : score;
  assign src_sat   = (src > SAT) ? SAT : src;
  assign disp_data = {best_bcd, 8'h00, score_bcd};

  // Add 3 to every BCD nibble of 5 or more ahead of the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i+:4] >= 4'd5)
        bcd_adj[4*i+:4] = bcd[4*i+:4] + 4'd3;
    end
  end

  // Best-score tracking on death edges, clear has priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_state <= 2'd0;
      best_bin   <= 11'd0;
      new_best   <= 1'b0;
    end else begin
      prev_state <= state;
      if (clear_best) begin
        best_bin <= 11'd0;
        new_best <= 1'b0;
      end else if (death && (score > best_bin)) begin
        best_bin <= score;
        new_best <= 1'b1;
      end else if (state == 2'd0) begin
        new_best <= 1'b0;
      end
    end
  end

  // Next-state: current score wins over best when both are pending
  always_comb begin
    fsm_nxt = fsm;
    tgt_nxt = target;
    unique case (fsm)
      IDLE: begin
        if (pend_cur) begin
          fsm_nxt = LOAD;
          tgt_nxt = 1'b0;
        end else if (pend_best) begin
          fsm_nxt = LOAD;
          tgt_nxt = 1'b1;
        end
      end
      LOAD:  fsm_nxt = SHIFT;
      SHIFT: if (cnt == 4'd10) fsm_nxt = STORE;
      STORE: fsm_nxt = IDLE;
    endcase
  end

  // State register and conversion target
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm    <= IDLE;
      target <= 1'b0;
    end else begin
      fsm    <= fsm_nxt;
      target <= tgt_nxt;
    end
  end

  // Conversion datapath; outputs only move in STORE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_cur  <= 11'd0;
      last_best <= 11'd0;
      bcd       <= 12'd0;
      bin       <= 11'd0;
      cnt       <= 4'd0;
      score_bcd <= 12'd0;
      best_bcd  <= 12'd0;
      sat       <= 1'b0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= (fsm == IDLE) && !pend_cur && !pend_best;
      unique case (fsm)
        IDLE: ;
        LOAD: begin
          if (target) last_best <= best_bin;
          else        last_cur  <= score;
          bin <= src_sat;
          bcd <= 12'd0;
          cnt <= 4'd0;
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj[10:0], bin, 1'b0};
          cnt        <= cnt + 4'd1;
        end
        STORE: begin
          if (target) begin
            best_bcd <= bcd;
          end else begin
            score_bcd <= bcd;
            sat       <= (last_cur > SAT);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_tracker.sv
// Bench for score_bcd_tracker: directed scenarios plus an
// arithmetic reference model checked every settled cycle.
module tb_score_bcd_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  state = 2'd0;
  logic [10:0] score = 11'd0;
  logic        clear_best = 1'b0;
  logic [11:0] score_bcd;
  logic [11:0] best_bcd;
  logic [31:0] disp_data;
  logic        bcd_valid;
  logic        new_best;
  logic        sat;

  int n_cmp = 0;
  int n_bad = 0;

  int m_best = 0;
  bit m_nb = 1'b0;
  int m_prev = 0;
  int quiet = 0;
  int p_score = 0;
  int p_best = 0;

  localparam int SETTLE = 45;

  score_bcd_tracker dut (
    .clk(clk),
    .rst(rst),
    .state(state),
    .score(score),
    .clear_best(clear_best),
    .score_bcd(score_bcd),
    .best_bcd(best_bcd),
    .disp_data(disp_data),
    .bcd_valid(bcd_valid),
    .new_best(new_best),
    .sat(sat)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(int v);
    int c;
    c = (v > 999) ? 999 : v;
    return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  function automatic bit legal(logic [11:0] b);
    return (b[11:8] <= 4'd9) && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    bit d;
    @(posedge clk);
    if (rst) begin
      d = (state == 2'd2) && (m_prev != 2);
      if (clear_best) begin
        m_best = 0;
        m_nb = 1'b0;
      end else if (d && (int'(score) > m_best)) begin
        m_best = int'(score);
        m_nb = 1'b1;
      end else if (state == 2'd0) begin
        m_nb = 1'b0;
      end
      m_prev = int'(state);
    end
    if (int'(score) != p_score || m_best != p_best) quiet = 0;
    else quiet++;
    p_score = int'(score);
    p_best = m_best;
    #1;
    chk("legal_nibbles", {31'd0, legal(score_bcd) & legal(best_bcd)}, 32'd1);
    chk("new_best", {31'd0, new_best}, {31'd0, m_nb});
    if (quiet >= SETTLE) begin
      chk("m_score_bcd", {20'd0, score_bcd}, {20'd0, to_bcd(int'(score))});
      chk("m_best_bcd", {20'd0, best_bcd}, {20'd0, to_bcd(m_best)});
      chk("m_disp", disp_data,
          {to_bcd(m_best), 8'h00, to_bcd(int'(score))});
      chk("m_sat", {31'd0, sat}, {31'd0, score > 11'd999});
      chk("m_valid", {31'd0, bcd_valid}, 32'd1);
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic model_reset();
    m_best = 0;
    m_nb = 1'b0;
    m_prev = 0;
    quiet = 0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_score"}, {20'd0, score_bcd}, 32'd0);
    chk({tag, "_best"}, {20'd0, best_bcd}, 32'd0);
    chk({tag, "_disp"}, disp_data, 32'd0);
    chk({tag, "_flags"}, {29'd0, bcd_valid, new_best, sat}, 32'd0);
  endtask

  int seq[8] = '{2047, 5, 999, 1000, 88, 640, 1234, 9};

  initial begin
    model_reset();
    ticks(2);
    rst = 1'b1;
    #1;
    chk_zero("reset");
    tick();
    chk("valid_first_idle", {31'd0, bcd_valid}, 32'd1);
    ticks(3);

    score = 11'd123;
    tick();
    chk("valid_drop_t1", {31'd0, bcd_valid}, 32'd0);
    ticks(12);
    chk("score_t13_old", {20'd0, score_bcd}, 32'h000);
    tick();
    chk("score_t14", {20'd0, score_bcd}, 32'h123);
    chk("disp_t14", disp_data, 32'h0000_0123);
    chk("valid_t14", {31'd0, bcd_valid}, 32'd0);
    tick();
    chk("valid_t15", {31'd0, bcd_valid}, 32'd1);
    ticks(50);

    score = 11'd1500;
    ticks(20);
    chk("sat_bcd", {20'd0, score_bcd}, 32'h999);
    chk("sat_flag", {31'd0, sat}, 32'd1);
    score = 11'd42;
    ticks(20);
    chk("unsat_bcd", {20'd0, score_bcd}, 32'h042);
    chk("unsat_flag", {31'd0, sat}, 32'd0);

    state = 2'd1;
    ticks(3);
    score = 11'd57;
    ticks(20);
    state = 2'd2;
    tick();
    chk("nb_on_death", {31'd0, new_best}, 32'd1);
    ticks(30);
    chk("best_57", {20'd0, best_bcd}, 32'h057);
    chk("nb_hold", {31'd0, new_best}, 32'd1);
    chk("disp_best", disp_data, 32'h0570_0057);
    state = 2'd0;
    tick();
    chk("nb_clear", {31'd0, new_best}, 32'd0);
    score = 11'd30;
    ticks(20);
    state = 2'd1;
    ticks(2);
    state = 2'd2;
    ticks(30);
    chk("best_keep", {20'd0, best_bcd}, 32'h057);
    chk("nb_low_keep", {31'd0, new_best}, 32'd0);
    state = 2'd0;
    ticks(50);

    score = 11'd777;
    ticks(8);
    rst = 1'b0;
    #1;
    model_reset();
    chk_zero("midreset");
    score = 11'd0;
    ticks(2);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("no_stale_score", {20'd0, score_bcd}, 32'h000);
      chk("no_stale_best", {20'd0, best_bcd}, 32'h000);
    end

    score = 11'd20;
    ticks(20);
    state = 2'd1;
    ticks(2);
    state = 2'd2;
    tick();
    state = 2'd0;
    ticks(30);
    chk("best_20", {20'd0, best_bcd}, 32'h020);
    state = 2'd1;
    ticks(2);
    score = 11'd80;
    ticks(20);
    state = 2'd2;
    clear_best = 1'b1;
    tick();
    clear_best = 1'b0;
    chk("clr_nb", {31'd0, new_best}, 32'd0);
    ticks(30);
    chk("clr_best", {20'd0, best_bcd}, 32'h000);
    chk("clr_nb_hold", {31'd0, new_best}, 32'd0);
    state = 2'd0;
    ticks(10);

    for (int i = 0; i < 8; i++) begin
      score = 11'(seq[i]);
      ticks(5);
    end
    score = 11'd321;
    ticks(SETTLE + 2);
    chk("churn_final", {20'd0, score_bcd}, 32'h321);
    chk("churn_valid", {31'd0, bcd_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
